// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial SRAM memory bridge and related load paths.
package mem_pkg;

   // Bit positions inside the 4-bit mem_size field {LB, LBU, LH, LHU}.
   localparam int MEM_SZ_LB  = 3;
   localparam int MEM_SZ_LBU = 2;
   localparam int MEM_SZ_LH  = 1;
   localparam int MEM_SZ_LHU = 0;
   localparam logic [3:0] MEM_SZ_WORD = 4'b0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SETUP,
      S_STROBE,
      S_DONE,
      S_HOLD
   } mem_bridge_state_t;

   // Number of bytes moved for a given size code; byte sizes outrank halfword sizes.
   function automatic logic [2:0] size_to_bytes(input logic [3:0] size);
      if (size[MEM_SZ_LB] | size[MEM_SZ_LBU]) begin
         return 3'd1;
      end else if (size[MEM_SZ_LH] | size[MEM_SZ_LHU]) begin
         return 3'd2;
      end else begin
         return 3'd4;
      end
   endfunction

endpackage

// File: rtl/mem_extend.sv
// Sign/zero extension of little-endian load data according to the size code.
module mem_extend
   import mem_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [3:0]  mem_size,
   output logic [31:0] mem_out
);

   // Highest set size bit selects the extension; no bits set passes the word through.
   always_comb begin
      mem_out = raw;
      if (mem_size[MEM_SZ_LB]) begin
         mem_out = {{24{raw[7]}}, raw[7:0]};
      end else if (mem_size[MEM_SZ_LBU]) begin
         mem_out = {24'h000000, raw[7:0]};
      end else if (mem_size[MEM_SZ_LH]) begin
         mem_out = {{16{raw[15]}}, raw[15:0]};
      end else if (mem_size[MEM_SZ_LHU]) begin
         mem_out = {16'h0000, raw[15:0]};
      end
   end

endmodule

// File: rtl/mem_bridge.sv
// Turns a 32-bit load/store request into a byte-serial access sequence on an 8-bit async SRAM.
//
// Handshake: a request is accepted only in IDLE, on a clock edge where mem_addr_ready is high
// together with mem_read or mem_write; inputs are sampled on that edge. Completion is a
// one-cycle mem_data_ready pulse (with mem_bus/mem_out valid for reads). The bridge then waits
// in HOLD until mem_addr_ready is seen low, so a strobe left high is never accepted twice.
module mem_bridge
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [3:0]        mem_size,
   input  logic              mem_addr_ready,
   output logic              mem_data_ready,
   output logic [31:0]       mem_out,
   output logic              mem_bus,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dq_out,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_in,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output mem_bridge_state_t dbg_state
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   mem_bridge_state_t state, state_nx;
   logic [1:0]        k, k_nx;
   logic [2:0]        wcnt, wcnt_nx;
   logic [ADDR_W-1:0] base, base_nx;
   logic [31:0]       wdata_r, wdata_nx;
   logic [3:0]        size_r;
   logic              is_write;
   logic [31:0]       raw;
   logic [31:0]       ext;
   logic              accept;
   logic              slot_last;
   logic [1:0]        last_k;
   logic              active_nx;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^addr[31:ADDR_W];

   assign accept    = (state == S_IDLE) && mem_addr_ready && (mem_read || mem_write);
   assign slot_last = (wcnt == WS);
   assign last_k    = 2'(size_to_bytes(size_r) - 3'd1);
   assign base_nx   = accept ? addr[ADDR_W-1:0] : base;
   assign wdata_nx  = accept ? wdata : wdata_r;
   assign active_nx = (state_nx == S_READ) || (state_nx == S_SETUP) || (state_nx == S_STROBE);

   // Next-state logic: byte index k and per-slot wait counter advance with the FSM.
   always_comb begin
      state_nx = state;
      k_nx     = k;
      wcnt_nx  = wcnt;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nx = mem_write ? S_SETUP : S_READ;
               k_nx     = 2'd0;
               wcnt_nx  = 3'd0;
            end
         end
         S_READ: begin
            if (slot_last) begin
               wcnt_nx = 3'd0;
               if (k == last_k) begin
                  state_nx = S_DONE;
               end else begin
                  k_nx = k + 2'd1;
               end
            end else begin
               wcnt_nx = wcnt + 3'd1;
            end
         end
         S_SETUP: begin
            state_nx = S_STROBE;
            wcnt_nx  = 3'd0;
         end
         S_STROBE: begin
            if (slot_last) begin
               wcnt_nx = 3'd0;
               if (k == last_k) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_SETUP;
                  k_nx     = k + 2'd1;
               end
            end else begin
               wcnt_nx = wcnt + 3'd1;
            end
         end
         S_DONE: state_nx = S_HOLD;
         S_HOLD: begin
            if (!mem_addr_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State, request latches and read-lane capture; lanes clear at accept so unread lanes are 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         k        <= 2'd0;
         wcnt     <= 3'd0;
         base     <= '0;
         wdata_r  <= 32'h0;
         size_r   <= MEM_SZ_WORD;
         is_write <= 1'b0;
         raw      <= 32'h0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
         wcnt  <= wcnt_nx;
         if (accept) begin
            base     <= addr[ADDR_W-1:0];
            wdata_r  <= wdata;
            size_r   <= mem_size;
            is_write <= mem_write;
            raw      <= 32'h0;
         end else if ((state == S_READ) && slot_last) begin
            raw[8*k +: 8] <= sram_dq_in;
         end
      end
   end

   // SRAM pins are registered from next-state values so strobes line up with states, glitch-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sram_addr   <= '0;
         sram_dq_out <= 8'h00;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
      end else begin
         sram_ce_n  <= !active_nx;
         sram_oe_n  <= !(state_nx == S_READ);
         sram_we_n  <= !(state_nx == S_STROBE);
         sram_dq_oe <= (state_nx == S_SETUP) || (state_nx == S_STROBE);
         if (active_nx) begin
            sram_addr   <= base_nx + ADDR_W'(k_nx);
            sram_dq_out <= wdata_nx[8*k_nx +: 8];
         end
      end
   end

   mem_extend u_extend (
      .raw      (raw),
      .mem_size (size_r),
      .mem_out  (ext)
   );

   assign mem_data_ready = (state == S_DONE);
   assign mem_bus        = mem_data_ready && !is_write;
   assign mem_out        = mem_bus ? ext : 32'h0;
   assign dbg_state      = state;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed scoreboard bench for mem_bridge with behavioural async SRAM models.
module tb_mem_bridge;
   import mem_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic        is_read;
      int          issue;
      int          lat;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   int   cyc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A: WAIT_STATES = 0 ----------------
   logic [31:0]       addr, wdata;
   logic              mem_read, mem_write, mem_addr_ready;
   logic [3:0]        mem_size;
   logic              mem_data_ready, mem_bus;
   logic [31:0]       mem_out;
   logic [18:0]       sram_addr;
   logic [7:0]        sram_dq_out, sram_dq_in;
   logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
   mem_bridge_state_t st_a;

   mem_bridge #(.ADDR_W(19), .WAIT_STATES(0)) dut_a (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
      .mem_addr_ready(mem_addr_ready), .mem_data_ready(mem_data_ready),
      .mem_out(mem_out), .mem_bus(mem_bus), .sram_addr(sram_addr),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .dbg_state(st_a)
   );

   // ---------------- DUT B: WAIT_STATES = 2 ----------------
   logic [31:0]       b_addr, b_wdata;
   logic              b_read, b_write, b_req;
   logic [3:0]        b_size;
   logic              b_ready, b_bus;
   logic [31:0]       b_out;
   logic [18:0]       b_sram_addr;
   logic [7:0]        b_dq_out, b_dq_in;
   logic              b_dq_oe, b_ce_n, b_oe_n, b_we_n;
   mem_bridge_state_t st_b;

   mem_bridge #(.ADDR_W(19), .WAIT_STATES(2)) dut_b (
      .clk(clk), .reset(reset), .addr(b_addr), .wdata(b_wdata),
      .mem_read(b_read), .mem_write(b_write), .mem_size(b_size),
      .mem_addr_ready(b_req), .mem_data_ready(b_ready),
      .mem_out(b_out), .mem_bus(b_bus), .sram_addr(b_sram_addr),
      .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in),
      .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
      .dbg_state(st_b)
   );

   // ---------------- SRAM models ----------------
   logic [7:0] mem_a [0:524287];
   logic [7:0] mem_b [0:524287];
   int we_pulses;
   int b_oe_low;
   int b_oe_falls;

   assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem_a[sram_addr] : 8'h00;
   assign b_dq_in    = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr] : 8'h00;

   always @(posedge clk) begin
      if (reset && !sram_ce_n && !sram_we_n && sram_dq_oe) mem_a[sram_addr] = sram_dq_out;
      if (reset && !b_ce_n && !b_we_n && b_dq_oe) mem_b[b_sram_addr] = b_dq_out;
   end

   always @(negedge sram_we_n) we_pulses++;
   always @(negedge b_oe_n) b_oe_falls++;
   always @(negedge clk) if (!b_oe_n) b_oe_low++;

   // ---------------- scoreboard ----------------
   exp_t exp_a_q[$];
   exp_t exp_b_q[$];
   int   total;
   int   bad;
   logic prev_done_a;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor A: pop one expectation per completion pulse, check latency, bus enable and data.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         if (prev_done_a) begin
            chk("ready_pulse_width", {31'h0, mem_data_ready}, 32'h0);
            chk("bus_after_done", {31'h0, mem_bus}, 32'h0);
         end
         if (mem_data_ready) begin
            if (exp_a_q.size() == 0) begin
               chk("unexpected_done_a", 32'h1, 32'h0);
            end else begin
               e = exp_a_q.pop_front();
               chk("latency_a", 32'(cyc - e.issue), 32'(e.lat));
               chk("mem_bus_a", {31'h0, mem_bus}, {31'h0, e.is_read});
               if (e.is_read) chk("mem_out_a", mem_out, e.data);
            end
         end
         prev_done_a = mem_data_ready;
      end else begin
         prev_done_a = 1'b0;
      end
   end

   // Monitor B: same scheme for the wait-state instance.
   always @(negedge clk) begin
      exp_t e;
      if (reset && b_ready) begin
         if (exp_b_q.size() == 0) begin
            chk("unexpected_done_b", 32'h1, 32'h0);
         end else begin
            e = exp_b_q.pop_front();
            chk("latency_b", 32'(cyc - e.issue), 32'(e.lat));
            chk("mem_bus_b", {31'h0, b_bus}, {31'h0, e.is_read});
            if (e.is_read) chk("mem_out_b", b_out, e.data);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_a(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, input logic [3:0] sz, input logic [31:0] expd,
                          input int lat, input bit push);
      @(negedge clk);
      addr = a; wdata = d; mem_read = rd; mem_write = wr; mem_size = sz;
      mem_addr_ready = 1'b1;
      if (push) exp_a_q.push_back('{data: expd, is_read: rd & ~wr, issue: cyc, lat: lat});
   endtask

   task automatic wait_done_a();
      int n;
      n = 0;
      while (!mem_data_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!mem_data_ready) chk("timeout_a", 32'h0, 32'h1);
   endtask

   task automatic txn_a(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, input logic [3:0] sz, input logic [31:0] expd,
                        input int lat);
      drive_a(a, d, rd, wr, sz, expd, lat, 1'b1);
      @(negedge clk);
      mem_addr_ready = 1'b0;
      wait_done_a();
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset = 1'b0;
      addr = 0; wdata = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_addr_ready = 0;
      b_addr = 0; b_wdata = 0; b_read = 0; b_write = 0; b_size = 0; b_req = 0;
      total = 0; bad = 0; we_pulses = 0; b_oe_low = 0; b_oe_falls = 0; prev_done_a = 0;
      mem_a[19'h00100] = 8'h78; mem_a[19'h00101] = 8'h56;
      mem_a[19'h00102] = 8'h34; mem_a[19'h00103] = 8'h12;
      mem_a[19'h00201] = 8'h01; mem_a[19'h00202] = 8'h80; mem_a[19'h00203] = 8'h80;
      mem_a[19'h7FFFE] = 8'h00; mem_a[19'h7FFFF] = 8'h00;
      mem_a[19'h00000] = 8'h00; mem_a[19'h00001] = 8'h00; mem_a[19'h00300] = 8'h00;
      mem_b[19'h00040] = 8'h34; mem_b[19'h00041] = 8'h92;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_state", 32'(st_a), 32'(S_IDLE));
      chk("rst_ready", {31'h0, mem_data_ready}, 32'h0);
      chk("rst_bus", {31'h0, mem_bus}, 32'h0);
      chk("rst_out", mem_out, 32'h0);
      chk("rst_strobes", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      chk("rst_addr", {13'h0, sram_addr}, 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // word load, then byte/half loads with both extensions
      txn_a(32'h0000_0100, 32'h0, 1, 0, MEM_SZ_WORD, 32'h1234_5678, 5);
      txn_a(32'h0000_0203, 32'h0, 1, 0, 4'b1000, 32'hFFFF_FF80, 2);
      txn_a(32'h0000_0203, 32'h0, 1, 0, 4'b0100, 32'h0000_0080, 2);
      txn_a(32'h0000_0201, 32'h0, 1, 0, 4'b0010, 32'hFFFF_8001, 3);
      txn_a(32'h0000_0201, 32'h0, 1, 0, 4'b0001, 32'h0000_8001, 3);
      txn_a(32'h0000_0201, 32'h0, 1, 0, 4'b1010, 32'h0000_0001, 2);  // LB outranks LH
      txn_a(32'hFFF0_0100, 32'h0, 1, 0, MEM_SZ_WORD, 32'h1234_5678, 5);  // upper addr bits ignored

      // word store across the top of the address space
      we_pulses = 0;
      txn_a(32'h0007_FFFE, 32'hDEAD_BEEF, 0, 1, MEM_SZ_WORD, 32'h0, 9);
      chk("we_pulses", 32'(we_pulses), 32'd4);
      chk("wr_7fffe", {24'h0, mem_a[19'h7FFFE]}, 32'h0000_00EF);
      chk("wr_7ffff", {24'h0, mem_a[19'h7FFFF]}, 32'h0000_00BE);
      chk("wr_00000", {24'h0, mem_a[19'h00000]}, 32'h0000_00AD);
      chk("wr_00001", {24'h0, mem_a[19'h00001]}, 32'h0000_00DE);
      txn_a(32'h0007_FFFE, 32'h0, 1, 0, MEM_SZ_WORD, 32'hDEAD_BEEF, 5);

      // both qualifiers set: the store is performed
      txn_a(32'h0000_0300, 32'h0000_00A5, 1, 1, 4'b1000, 32'h0, 3);
      chk("wr_wins", {24'h0, mem_a[19'h00300]}, 32'h0000_00A5);

      // wait states on instance B: signed halfword load
      b_oe_low = 0; b_oe_falls = 0;
      @(negedge clk);
      b_addr = 32'h40; b_read = 1; b_write = 0; b_size = 4'b0010; b_req = 1;
      exp_b_q.push_back('{data: 32'hFFFF_9234, is_read: 1'b1, issue: cyc, lat: 7});
      @(negedge clk);
      b_req = 0;
      n = 0;
      while (!b_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!b_ready) chk("timeout_b", 32'h0, 32'h1);
      repeat (2) @(negedge clk);
      chk("b_oe_low_cycles", 32'(b_oe_low), 32'd6);
      chk("b_oe_single_run", 32'(b_oe_falls), 32'd1);

      // strobe left high past completion: no second transaction
      drive_a(32'h0000_0100, 32'h0, 1, 0, MEM_SZ_WORD, 32'h1234_5678, 5, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_data_ready && n < 100);
      if (!mem_data_ready) chk("timeout_hold", 32'h0, 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_state", 32'(st_a), 32'(S_HOLD));
         chk("hold_ce_n", {31'h0, sram_ce_n}, 32'h1);
      end
      mem_addr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("hold_release", 32'(st_a), 32'(S_IDLE));
      txn_a(32'h0000_0203, 32'h0, 1, 0, 4'b0100, 32'h0000_0080, 2);

      // reset during the second write strobe
      drive_a(32'h0000_0500, 32'h1122_3344, 0, 1, MEM_SZ_WORD, 32'h0, 9, 1'b0);
      @(negedge clk);
      mem_addr_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_abort_state", 32'(st_a), 32'(S_STROBE));
      chk("pre_abort_we_n", {31'h0, sram_we_n}, 32'h0);
      #1 reset = 1'b0;
      #1;
      chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
      chk("abort_ce_n", {31'h0, sram_ce_n}, 32'h1);
      chk("abort_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("post_abort_state", 32'(st_a), 32'(S_IDLE));
      txn_a(32'h0000_0100, 32'h0, 1, 0, MEM_SZ_WORD, 32'h1234_5678, 5);

      repeat (3) @(negedge clk);
      chk("exp_a_drained", 32'(exp_a_q.size()), 32'h0);
      chk("exp_b_drained", 32'(exp_b_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "time limit");
   end

endmodule
